// File: rtl/loop_ctrl_pkg.sv
// rtl/loop_ctrl_pkg.sv - shared state encoding and parameter checks for the gate-enable sequencer
package loop_ctrl_pkg;

    localparam int CNT_W_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DT_L  = 3'd1,
        ST_LS_ON = 3'd2,
        ST_DT_H  = 3'd3,
        ST_HS_ON = 3'd4,
        ST_FAULT = 3'd5
    } state_t;

    function automatic bit cnt_param_ok(input int cnt_w, input int val);
        return (val >= 1) && (val <= (1 << cnt_w) - 1);
    endfunction

endpackage

// File: rtl/loop_ctrl_dt_counter.sv
// rtl/loop_ctrl_dt_counter.sv - loadable down-counter, saturating at 0, with zero flag
module loop_ctrl_dt_counter #(
    parameter int CNT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/loop_ctrl_nonoverlap_seq.sv
// rtl/loop_ctrl_nonoverlap_seq.sv - non-overlapping HS/LS gate-enable sequencer with dead time and min-on
// Optional sticky fault (cleared by clr) when LOOP_CTRL_FAULT_LATCH_EN is defined.
module loop_ctrl_nonoverlap_seq
    import loop_ctrl_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int DT_HS  = 3,
    parameter int DT_LS  = 3,
    parameter int MIN_ON = 2
) (
    input  logic       CELCLK,
    input  logic       CELRSTB,
    input  logic       CELV,
    input  logic       CELG,
    input  logic       SUB,
    input  logic       en,
    input  logic       pwm_req,
    input  logic [2:0] fault,
    input  logic       clr,
    output logic       hs_en,
    output logic       ls_en,
    output logic       fault_o,
    output logic [2:0] state_o
);

    generate
        if (!cnt_param_ok(CNT_W, DT_HS) || !cnt_param_ok(CNT_W, DT_LS) ||
            !cnt_param_ok(CNT_W, MIN_ON)) begin : g_bad_param
            $error("loop_ctrl_nonoverlap_seq: DT_HS/DT_LS/MIN_ON out of range for CNT_W");
        end
    endgenerate

    localparam logic [CNT_W-1:0] LD_DT_HS = CNT_W'(DT_HS - 1);
    localparam logic [CNT_W-1:0] LD_DT_LS = CNT_W'(DT_LS - 1);
    localparam logic [CNT_W-1:0] LD_MIN   = CNT_W'(MIN_ON - 1);

    state_t           r_state;
    state_t           w_nxt;
    logic             r_hs_en;
    logic             r_ls_en;
    logic             r_fault;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_zero;
    logic             w_fault_exit;
    logic             w_illegal;
    logic             w_unused;

`ifdef LOOP_CTRL_FAULT_LATCH_EN
    assign w_fault_exit = clr;
`else
    assign w_fault_exit = 1'b1;
`endif

    // Power pins carry no logic; clr is idle when the fault latch is compiled out.
    assign w_unused  = ^{CELV, CELG, SUB, clr};
    assign w_illegal = (r_state > ST_FAULT);

    always_comb begin
        w_nxt      = r_state;
        w_load     = 1'b0;
        w_load_val = '0;
        if ((|fault) || w_illegal) begin
            w_nxt  = ST_FAULT;
            w_load = 1'b1;
        end else if (!en && (r_state != ST_FAULT)) begin
            w_nxt  = ST_IDLE;
            w_load = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt      = ST_DT_L;
                    w_load     = 1'b1;
                    w_load_val = LD_DT_LS;
                end
                ST_DT_L: if (w_zero) begin
                    w_nxt      = ST_LS_ON;
                    w_load     = 1'b1;
                    w_load_val = LD_MIN;
                end
                ST_LS_ON: if (w_zero && pwm_req) begin
                    w_nxt      = ST_DT_H;
                    w_load     = 1'b1;
                    w_load_val = LD_DT_HS;
                end
                ST_DT_H: if (w_zero) begin
                    w_nxt      = ST_HS_ON;
                    w_load     = 1'b1;
                    w_load_val = LD_MIN;
                end
                ST_HS_ON: if (w_zero && !pwm_req) begin
                    w_nxt      = ST_DT_L;
                    w_load     = 1'b1;
                    w_load_val = LD_DT_LS;
                end
                ST_FAULT: if (w_fault_exit) begin
                    w_nxt  = ST_IDLE;
                    w_load = 1'b1;
                end
                default: begin
                    w_nxt  = ST_FAULT;
                    w_load = 1'b1;
                end
            endcase
        end
    end

    loop_ctrl_dt_counter #(
        .CNT_W (CNT_W)
    ) u_dt_counter (
        .i_clk      (CELCLK),
        .i_rst_n    (CELRSTB),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    // Enables are decoded from the next state so they change on the same edge as state_o.
    always_ff @(posedge CELCLK or negedge CELRSTB) begin
        if (!CELRSTB) begin
            r_state <= ST_IDLE;
            r_hs_en <= 1'b0;
            r_ls_en <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_hs_en <= (w_nxt == ST_HS_ON);
            r_ls_en <= (w_nxt == ST_LS_ON);
            r_fault <= (w_nxt == ST_FAULT);
        end
    end

    assign hs_en   = r_hs_en;
    assign ls_en   = r_ls_en;
    assign fault_o = r_fault;
    assign state_o = r_state;

endmodule

// File: tb/tb_loop_ctrl_nonoverlap_seq.sv
// tb/tb_loop_ctrl_nonoverlap_seq.sv - directed and random checks of the sequencer against a phase-age model
module tb_loop_ctrl_nonoverlap_seq;

    localparam int DT_HS  = 3;
    localparam int DT_LS  = 3;
    localparam int MIN_ON = 2;

    localparam int S_IDLE  = 0;
    localparam int S_DT_L  = 1;
    localparam int S_LS_ON = 2;
    localparam int S_DT_H  = 3;
    localparam int S_HS_ON = 4;
    localparam int S_FAULT = 5;

    logic       CELCLK = 1'b0;
    logic       CELRSTB;
    logic       CELV = 1'b1;
    logic       CELG = 1'b0;
    logic       SUB  = 1'b0;
    logic       en;
    logic       pwm_req;
    logic [2:0] fault;
    logic       clr;
    logic       hs_en;
    logic       ls_en;
    logic       fault_o;
    logic [2:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;
    int m_st  = S_IDLE;
    int m_age = 0;

    always #5 CELCLK = ~CELCLK;

    loop_ctrl_nonoverlap_seq dut (
        .CELCLK  (CELCLK),
        .CELRSTB (CELRSTB),
        .CELV    (CELV),
        .CELG    (CELG),
        .SUB     (SUB),
        .en      (en),
        .pwm_req (pwm_req),
        .fault   (fault),
        .clr     (clr),
        .hs_en   (hs_en),
        .ls_en   (ls_en),
        .fault_o (fault_o),
        .state_o (state_o)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: each phase tracks how many cycles it has been held (m_age).
    task automatic model_step();
        int nxt;
        nxt = m_st;
        if (fault != 3'b000) begin
            nxt = S_FAULT;
        end else if (!en && m_st != S_FAULT) begin
            nxt = S_IDLE;
        end else begin
            case (m_st)
                S_IDLE:  nxt = S_DT_L;
                S_DT_L:  if (m_age >= DT_LS) nxt = S_LS_ON;
                S_LS_ON: if (m_age >= MIN_ON && pwm_req) nxt = S_DT_H;
                S_DT_H:  if (m_age >= DT_HS) nxt = S_HS_ON;
                S_HS_ON: if (m_age >= MIN_ON && !pwm_req) nxt = S_DT_L;
`ifdef LOOP_CTRL_FAULT_LATCH_EN
                S_FAULT: if (clr) nxt = S_IDLE;
`else
                S_FAULT: nxt = S_IDLE;
`endif
                default: nxt = S_FAULT;
            endcase
        end
        m_age = (nxt == m_st) ? m_age + 1 : 1;
        m_st  = nxt;
    endtask

    task automatic cyc();
        @(posedge CELCLK);
        model_step();
        #1;
        chk("state", int'(state_o), m_st);
        chk("hs_en", int'(hs_en), int'(m_st == S_HS_ON));
        chk("ls_en", int'(ls_en), int'(m_st == S_LS_ON));
        chk("fault_o", int'(fault_o), int'(m_st == S_FAULT));
        chk("no_overlap", int'(hs_en & ls_en), 0);
    endtask

    task automatic count_dead(output int n);
        int g;
        n = (!hs_en && !ls_en) ? 1 : 0;
        g = 0;
        while (!hs_en && !ls_en && g < 50) begin
            cyc();
            g++;
            if (!hs_en && !ls_en) n++;
        end
    endtask

    task automatic wait_ls();
        int g;
        g = 0;
        while (!ls_en && g < 50) begin
            cyc();
            g++;
        end
    endtask

    initial begin
        int n;
        CELRSTB = 1'b0;
        en      = 1'b0;
        pwm_req = 1'b0;
        fault   = 3'b000;
        clr     = 1'b0;
        repeat (2) @(negedge CELCLK);
        chk("rst_state", int'(state_o), S_IDLE);
        chk("rst_hs", int'(hs_en), 0);
        chk("rst_ls", int'(ls_en), 0);
        chk("rst_fault", int'(fault_o), 0);
        CELRSTB = 1'b1;

        // 1: startup into low side
        en = 1'b1;
        n  = 0;
        do begin
            cyc();
            n++;
        end while (!ls_en && n < 50);
        chk("t1_ls_rise_edge", n, DT_LS + 1);

        // 2: request high side after min-on
        repeat (3) cyc();
        pwm_req = 1'b1;
        cyc();
        chk("t2_ls_drop", int'(ls_en), 0);
        count_dead(n);
        chk("t2_dead_cycles", n, DT_HS);
        repeat (MIN_ON) begin
            chk("t2_hs_hold", int'(hs_en), 1);
            cyc();
        end

        // 3: single-cycle pwm pulse from LS_ON
        pwm_req = 1'b0;
        wait_ls();
        repeat (3) cyc();
        pwm_req = 1'b1;
        cyc();
        pwm_req = 1'b0;
        count_dead(n);
        chk("t3_dead_h", n, DT_HS);
        n = 0;
        while (hs_en && n < 50) begin
            n++;
            cyc();
        end
        chk("t3_hs_width", n, MIN_ON);
        count_dead(n);
        chk("t3_dead_l", n, DT_LS);
        chk("t3_back_ls", int'(ls_en), 1);

        // 4: fault while HS_ON
        pwm_req = 1'b1;
        repeat (10) cyc();
        chk("t4_pre_hs", int'(hs_en), 1);
        fault = 3'b010;
        cyc();
        chk("t4_hs_off", int'(hs_en), 0);
        chk("t4_fault_o", int'(fault_o), 1);
        chk("t4_state", int'(state_o), S_FAULT);
        clr = 1'b1;
        cyc();
        chk("t4_clr_ignored", int'(state_o), S_FAULT);
        fault = 3'b000;
        clr   = 1'b0;
        cyc();
`ifdef LOOP_CTRL_FAULT_LATCH_EN
        chk("t4_latched", int'(state_o), S_FAULT);
        clr = 1'b1;
        cyc();
        clr = 1'b0;
        chk("t4_clr_exit", int'(state_o), S_IDLE);
`else
        chk("t4_auto_exit", int'(state_o), S_IDLE);
`endif
        cyc();
        chk("t4_restart_dtl", int'(state_o), S_DT_L);

        // 5: fault and pwm change together
        pwm_req = 1'b0;
        repeat (12) cyc();
        chk("t5_pre_ls", int'(ls_en), 1);
        fault   = 3'b001;
        pwm_req = 1'b1;
        n = 0;
        repeat (4) begin
            cyc();
            if (hs_en || ls_en) n++;
        end
        chk("t5_no_enable", n, 0);
        fault = 3'b000;
        clr   = 1'b1;
        cyc();
        clr = 1'b0;

        // 6: async reset in DT_H, then en low in HS_ON
        pwm_req = 1'b0;
        repeat (12) cyc();
        pwm_req = 1'b1;
        cyc();
        cyc();
        chk("t6_in_dth", int'(state_o), S_DT_H);
        #2;
        CELRSTB = 1'b0;
        #1;
        chk("t6_async_state", int'(state_o), S_IDLE);
        chk("t6_async_hs", int'(hs_en), 0);
        chk("t6_async_ls", int'(ls_en), 0);
        m_st  = S_IDLE;
        m_age = 0;
        @(negedge CELCLK);
        CELRSTB = 1'b1;
        repeat (12) cyc();
        chk("t6_pre_hs", int'(hs_en), 1);
        en = 1'b0;
        cyc();
        chk("t6_en_idle", int'(state_o), S_IDLE);
        chk("t6_en_hs", int'(hs_en), 0);
        en = 1'b1;

        // Random stress
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 5) == 0) pwm_req = ~pwm_req;
            fault = ($urandom_range(0, 59) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            en    = ($urandom_range(0, 199) != 0);
            clr   = ($urandom_range(0, 7) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
